// File: rtl/pixel_mixer_pkg.sv
// Shared definitions for the pixel compositor: colour field widths,
// colour slicing helpers and the per-layer configuration record.
package pixel_mixer_pkg;

    localparam int COLOR_W = 8;
    localparam int RED_W   = 3;
    localparam int GREEN_W = 3;
    localparam int BLUE_W  = 2;

    localparam logic [COLOR_W-1:0] WHITE = 8'hFF;
    localparam logic [COLOR_W-1:0] BLACK = 8'h00;

    // One layer's programmable state; colour packed as {r[2:0],g[2:0],b[1:0]}.
    typedef struct packed {
        logic               en;
        logic [COLOR_W-1:0] color;
    } layer_cfg_t;

    function automatic logic [RED_W-1:0] color_red(input logic [COLOR_W-1:0] c);
        return c[COLOR_W-1 -: RED_W];
    endfunction

    function automatic logic [GREEN_W-1:0] color_green(input logic [COLOR_W-1:0] c);
        return c[BLUE_W +: GREEN_W];
    endfunction

    function automatic logic [BLUE_W-1:0] color_blue(input logic [COLOR_W-1:0] c);
        return c[BLUE_W-1:0];
    endfunction

endpackage

// File: rtl/pixel_mixer_cfg_regs.sv
// Layer configuration: CPU-visible shadow registers and the active copy used
// by the mixer. Shadow is copied to active on the first pixel of vblank so
// colour/enable changes never tear a visible frame.
module pixel_mixer_cfg_regs
    import pixel_mixer_pkg::*;
#(
    parameter int               NUM_LAYERS = 4,
    parameter logic [COLOR_W-1:0] RST_COLOR = WHITE
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               pix_ce,
    input  logic                               vblank_in,
    input  logic                               cfg_wr,
    input  logic [$clog2(NUM_LAYERS+1)-1:0]    cfg_layer,
    input  logic                               cfg_en,
    input  logic [COLOR_W-1:0]                 cfg_color,
    output layer_cfg_t                         active_cfg [NUM_LAYERS],
    output logic                               frame_tick
);

    // The index port has one spare code point so out-of-range layers can be
    // presented and are simply not decoded.
    localparam int LIDX_W = $clog2(NUM_LAYERS + 1);

    localparam layer_cfg_t RST_CFG = '{en: 1'b1, color: RST_COLOR};

    layer_cfg_t shadow_cfg [NUM_LAYERS];
    logic       vblank_q;
    logic       commit;

    assign commit = pix_ce && vblank_in && !vblank_q;

    // Vblank edge detector (pixel rate) and the one-clock commit strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vblank_q   <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= commit;
            if (pix_ce) begin
                vblank_q <= vblank_in;
            end
        end
    end

    // Shadow registers: written on any clock; unmatched indices fall through.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: only a handful of flops, so every entry gets a reset value;
            // large RAM-style arrays would normally be left unreset.
            for (int i = 0; i < NUM_LAYERS; i++) begin
                shadow_cfg[i] <= RST_CFG;
            end
        end else if (cfg_wr) begin
            for (int i = 0; i < NUM_LAYERS; i++) begin
                if (cfg_layer == LIDX_W'(i)) begin
                    shadow_cfg[i] <= '{en: cfg_en, color: cfg_color};
                end
            end
        end
    end

    // Active registers: frame-boundary copy of the shadow set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_LAYERS; i++) begin
                active_cfg[i] <= RST_CFG;
            end
        end else if (commit) begin
            // NOTE: non-blocking assignment means this reads the shadow value
            // from before any same-clock cfg write, which then waits a frame.
            for (int i = 0; i < NUM_LAYERS; i++) begin
                active_cfg[i] <= shadow_cfg[i];
            end
        end
    end

endmodule

// File: rtl/pixel_mixer.sv
// N-layer priority compositor between the VGA timing generator and the RGB
// pins. Generates the pixel clock-enable, runs a two-stage pixel pipeline
// and delays hs/vs by the same amount as the colour.
module pixel_mixer
    import pixel_mixer_pkg::*;
#(
    parameter int                 NUM_LAYERS = 4,
    parameter int                 CE_DIV     = 2,
    parameter logic [COLOR_W-1:0] BG_COLOR   = 8'h00,
    parameter logic [COLOR_W-1:0] RST_COLOR  = 8'hFF
) (
    input  logic                               clk,
    input  logic                               rst_n,
    output logic                               pix_ce,
    input  logic [NUM_LAYERS-1:0]              layer_valid,
    input  logic                               hs_in,
    input  logic                               vs_in,
    input  logic                               blank_in,
    input  logic                               vblank_in,
    input  logic                               cfg_wr,
    input  logic [$clog2(NUM_LAYERS+1)-1:0]    cfg_layer,
    input  logic                               cfg_en,
    input  logic [COLOR_W-1:0]                 cfg_color,
    output logic                               frame_tick,
    output logic [RED_W-1:0]                   red,
    output logic [GREEN_W-1:0]                 green,
    output logic [BLUE_W-1:0]                  blue,
    output logic                               hs,
    output logic                               vs
);

    layer_cfg_t              active_cfg [NUM_LAYERS];
    logic [NUM_LAYERS-1:0]   s1_valid;
    logic                    s1_hs;
    logic                    s1_vs;
    logic                    s1_blank;
    logic                    hit;
    logic [COLOR_W-1:0]      sel_color;
    logic [COLOR_W-1:0]      next_color;

    generate
        if (CE_DIV == 1) begin : g_ce_const
            assign pix_ce = 1'b1;
        end else begin : g_ce_cnt
            localparam int CNT_W = $clog2(CE_DIV);
            localparam logic [CNT_W-1:0] CE_LAST = CNT_W'(CE_DIV - 1);

            logic [CNT_W-1:0] ce_cnt;

            // Free-running divider; pix_ce marks the last clk of each pixel.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ce_cnt <= '0;
                end else if (ce_cnt == CE_LAST) begin
                    ce_cnt <= '0;
                end else begin
                    ce_cnt <= ce_cnt + 1'b1;
                end
            end

            assign pix_ce = (ce_cnt == CE_LAST);
        end
    endgenerate

    pixel_mixer_cfg_regs #(
        .NUM_LAYERS (NUM_LAYERS),
        .RST_COLOR  (RST_COLOR)
    ) u_cfg_regs (
        .clk        (clk),
        .rst_n      (rst_n),
        .pix_ce     (pix_ce),
        .vblank_in  (vblank_in),
        .cfg_wr     (cfg_wr),
        .cfg_layer  (cfg_layer),
        .cfg_en     (cfg_en),
        .cfg_color  (cfg_color),
        .active_cfg (active_cfg),
        .frame_tick (frame_tick)
    );

    // S1: capture layer hits and timing; reset content reads as blanked, sync idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= '0;
            s1_hs    <= 1'b1;
            s1_vs    <= 1'b1;
            s1_blank <= 1'b1;
        end else if (pix_ce) begin
            s1_valid <= layer_valid;
            s1_hs    <= hs_in;
            s1_vs    <= vs_in;
            s1_blank <= blank_in;
        end
    end

    // Priority select: scanning downwards lets the lowest enabled hit win.
    always_comb begin
        // NOTE: defaults first so every path assigns and no latch is inferred.
        hit       = 1'b0;
        sel_color = BG_COLOR;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (s1_valid[i] && active_cfg[i].en) begin
                hit       = 1'b1;
                sel_color = active_cfg[i].color;
            end
        end
    end

    assign next_color = s1_blank ? BLACK : (hit ? sel_color : BG_COLOR);

    // S2: registered pins; sync follows S1 so colour and sync stay aligned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            red   <= '0;
            green <= '0;
            blue  <= '0;
            hs    <= 1'b1;
            vs    <= 1'b1;
        end else if (pix_ce) begin
            red   <= color_red(next_color);
            green <= color_green(next_color);
            blue  <= color_blue(next_color);
            hs    <= s1_hs;
            vs    <= s1_vs;
        end
    end

endmodule

// File: tb/tb_pixel_mixer.sv
// Self-checking bench for pixel_mixer: a pixel-level reference model checks
// every clock, plus a vector table and directed frame-boundary sequences.
module tb_pixel_mixer;
    import pixel_mixer_pkg::*;

    localparam int          N      = 4;
    localparam int          CE_DIV = 2;
    localparam logic [7:0]  BG     = 8'h00;
    localparam logic [7:0]  RSTC   = 8'hFF;

    logic         clk;
    logic         rst_n;
    logic         pix_ce;
    logic [N-1:0] layer_valid;
    logic         hs_in, vs_in, blank_in, vblank_in;
    logic         cfg_wr;
    logic [2:0]   cfg_layer;
    logic         cfg_en;
    logic [7:0]   cfg_color;
    logic         frame_tick;
    logic [2:0]   red;
    logic [2:0]   green;
    logic [1:0]   blue;
    logic         hs, vs;

    pixel_mixer #(
        .NUM_LAYERS (N),
        .CE_DIV     (CE_DIV),
        .BG_COLOR   (BG),
        .RST_COLOR  (RSTC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pix_ce      (pix_ce),
        .layer_valid (layer_valid),
        .hs_in       (hs_in),
        .vs_in       (vs_in),
        .blank_in    (blank_in),
        .vblank_in   (vblank_in),
        .cfg_wr      (cfg_wr),
        .cfg_layer   (cfg_layer),
        .cfg_en      (cfg_en),
        .cfg_color   (cfg_color),
        .frame_tick  (frame_tick),
        .red         (red),
        .green       (green),
        .blue        (blue),
        .hs          (hs),
        .vs          (vs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [N-1:0] valid;
        logic         blank;
        logic         hs;
        logic         vs;
    } pix_t;

    bit         m_sh_en  [N];
    logic [7:0] m_sh_col [N];
    bit         m_ac_en  [N];
    logic [7:0] m_ac_col [N];
    pix_t       m_s1;
    logic [7:0] m_rgb;
    logic       m_hs, m_vs, m_tick, m_vb_prev;
    int         n_edges;
    bit         in_reset;

    // First enabled hit in priority order wins; blank forces black.
    function automatic logic [7:0] mix(input pix_t p);
        if (p.blank) return 8'h00;
        for (int i = 0; i < N; i++)
            if (p.valid[i] && m_ac_en[i]) return m_ac_col[i];
        return BG;
    endfunction

    function automatic bit exp_ce();
        return !in_reset && ((n_edges % CE_DIV) == CE_DIV - 1);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_sh_en[i] = 1'b1; m_sh_col[i] = RSTC;
            m_ac_en[i] = 1'b1; m_ac_col[i] = RSTC;
        end
        m_s1      = {{N{1'b0}}, 1'b1, 1'b1, 1'b1};
        m_rgb     = 8'h00;
        m_hs      = 1'b1;
        m_vs      = 1'b1;
        m_tick    = 1'b0;
        m_vb_prev = 1'b0;
        n_edges   = 0;
    endtask

    // One clock: check pix_ce, advance model with the pre-edge inputs, check outputs.
    task automatic tick();
        bit         ce;
        pix_t       cur;
        logic       wr, we, vb;
        logic [2:0] wl;
        logic [7:0] wc;
        ce  = exp_ce();
        check("pix_ce", {31'd0, pix_ce}, {31'd0, ce});
        cur = {layer_valid, blank_in, hs_in, vs_in};
        wr = cfg_wr; wl = cfg_layer; we = cfg_en; wc = cfg_color; vb = vblank_in;
        @(posedge clk);
        #1;
        if (!in_reset) begin
            n_edges++;
            m_tick = 1'b0;
            if (ce) begin
                m_rgb = mix(m_s1);
                m_hs  = m_s1.hs;
                m_vs  = m_s1.vs;
                if (vb && !m_vb_prev) begin
                    for (int i = 0; i < N; i++) begin
                        m_ac_en[i]  = m_sh_en[i];
                        m_ac_col[i] = m_sh_col[i];
                    end
                    m_tick = 1'b1;
                end
                m_vb_prev = vb;
                m_s1      = cur;
            end
            if (wr && int'(wl) < N) begin
                m_sh_en[wl]  = we;
                m_sh_col[wl] = wc;
            end
        end
        check("model_rgb", {24'd0, red, green, blue}, {24'd0, m_rgb});
        check("model_hs", {31'd0, hs}, {31'd0, m_hs});
        check("model_vs", {31'd0, vs}, {31'd0, m_vs});
        check("model_tick", {31'd0, frame_tick}, {31'd0, m_tick});
    endtask

    // Advance through exactly one pix_ce edge; current inputs are sampled there.
    task automatic pixel();
        while (!exp_ce()) tick();
        tick();
    endtask

    task automatic cfg_write(input logic [2:0] l, input logic e, input logic [7:0] c);
        cfg_wr = 1'b1; cfg_layer = l; cfg_en = e; cfg_color = c;
        tick();
        cfg_wr = 1'b0;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        in_reset = 1'b1;
        model_reset();
        repeat (3) tick();
        rst_n    = 1'b1;
        in_reset = 1'b0;
    endtask

    function automatic logic [7:0] rgb();
        return {red, green, blue};
    endfunction

    // ---------------- vector table ----------------
    typedef struct {
        logic [N-1:0] valid;
        logic         blank;
        logic         hs;
        logic         vs;
        logic [7:0]   exp_rgb;
    } vec_t;

    vec_t vecs [8];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Layers programmed below: L0=92 L1=E0 L2=1C L3=49, all enabled.
        vecs[0] = '{4'b0000, 1'b0, 1'b1, 1'b1, 8'h00};
        vecs[1] = '{4'b0110, 1'b0, 1'b1, 1'b1, 8'hE0};
        vecs[2] = '{4'b0100, 1'b0, 1'b0, 1'b1, 8'h1C};
        vecs[3] = '{4'b1000, 1'b0, 1'b1, 1'b0, 8'h49};
        vecs[4] = '{4'b1111, 1'b0, 1'b1, 1'b1, 8'h92};
        vecs[5] = '{4'b1100, 1'b0, 1'b0, 1'b0, 8'h1C};
        vecs[6] = '{4'b1111, 1'b1, 1'b1, 1'b1, 8'h00};
        vecs[7] = '{4'b0001, 1'b0, 1'b1, 1'b1, 8'h92};

        rst_n = 1'b0; layer_valid = '0; hs_in = 1'b1; vs_in = 1'b1;
        blank_in = 1'b0; vblank_in = 1'b0;
        cfg_wr = 1'b0; cfg_layer = '0; cfg_en = 1'b0; cfg_color = '0;

        // Reset release: pix_ce low first, then every second clk.
        do_reset();
        check("ce_first_lo", {31'd0, pix_ce}, 32'd0);
        check("rst_rgb", {24'd0, rgb()}, 32'h00);
        check("rst_hs", {31'd0, hs}, 32'd1);
        tick();
        check("ce_first_hi", {31'd0, pix_ce}, 32'd1);
        tick();
        check("ce_second_lo", {31'd0, pix_ce}, 32'd0);

        // Program colours and commit them on a vblank rise.
        cfg_write(3'd0, 1'b1, 8'h92);
        cfg_write(3'd1, 1'b1, 8'hE0);
        cfg_write(3'd2, 1'b1, 8'h1C);
        cfg_write(3'd3, 1'b1, 8'h49);
        vblank_in = 1'b1; pixel();
        check("commit_tick", {31'd0, frame_tick}, 32'd1);
        vblank_in = 1'b0; pixel();

        for (int i = 0; i < 8; i++) begin
            layer_valid = vecs[i].valid; blank_in = vecs[i].blank;
            hs_in = vecs[i].hs; vs_in = vecs[i].vs;
            pixel(); pixel();
            check($sformatf("vec%0d_rgb", i), {24'd0, rgb()}, {24'd0, vecs[i].exp_rgb});
            check($sformatf("vec%0d_hs", i), {31'd0, hs}, {31'd0, vecs[i].hs});
            check($sformatf("vec%0d_vs", i), {31'd0, vs}, {31'd0, vecs[i].vs});
        end

        // Sync pulse during blank appears exactly two pixels later.
        layer_valid = 4'b1111; blank_in = 1'b1; hs_in = 1'b1; vs_in = 1'b1;
        pixel(); pixel();
        hs_in = 1'b0; vs_in = 1'b0; pixel();
        check("sync_d1_hs", {31'd0, hs}, 32'd1);
        hs_in = 1'b1; vs_in = 1'b1; pixel();
        check("sync_d2_hs", {31'd0, hs}, 32'd0);
        check("sync_d2_vs", {31'd0, vs}, 32'd0);
        check("sync_blank_rgb", {24'd0, rgb()}, 32'h00);
        pixel();
        check("sync_d3_hs", {31'd0, hs}, 32'd1);
        blank_in = 1'b0;

        // Disable L1 mid-frame: takes effect only after the vblank rise.
        layer_valid = 4'b0110;
        cfg_write(3'd1, 1'b0, 8'hE0);
        pixel(); pixel();
        check("dis_midframe_rgb", {24'd0, rgb()}, 32'hE0);
        vblank_in = 1'b1; pixel();
        check("dis_commit_tick", {31'd0, frame_tick}, 32'd1);
        check("dis_commit_rgb", {24'd0, rgb()}, 32'hE0);
        tick();
        check("dis_tick_1clk", {31'd0, frame_tick}, 32'd0);
        pixel();
        check("dis_after_rgb", {24'd0, rgb()}, 32'h1C);
        vblank_in = 1'b0; pixel();

        // cfg write in the commit clock lands next frame; index 4 is ignored.
        layer_valid = 4'b0001;
        pixel(); pixel();
        check("same_clk_pre", {24'd0, rgb()}, 32'h92);
        vblank_in = 1'b1;
        while (!exp_ce()) tick();
        cfg_wr = 1'b1; cfg_layer = 3'd0; cfg_en = 1'b1; cfg_color = 8'h03;
        tick();
        cfg_wr = 1'b0;
        check("same_clk_tick", {31'd0, frame_tick}, 32'd1);
        pixel();
        check("same_clk_old_l0", {24'd0, rgb()}, 32'h92);
        cfg_write(3'd4, 1'b1, 8'h55);
        vblank_in = 1'b0; pixel();
        vblank_in = 1'b1; pixel(); pixel();
        check("next_frame_l0", {24'd0, rgb()}, 32'h03);
        vblank_in = 1'b0;
        layer_valid = 4'b1000; pixel(); pixel();
        check("oob_l3_kept", {24'd0, rgb()}, 32'h49);

        // Asynchronous reset mid-line.
        layer_valid = 4'b0110; hs_in = 1'b0; vs_in = 1'b0;
        pixel(); pixel();
        check("pre_rst_rgb", {24'd0, rgb()}, 32'h1C);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_rgb", {24'd0, rgb()}, 32'h00);
        check("async_rst_hs", {31'd0, hs}, 32'd1);
        check("async_rst_vs", {31'd0, vs}, 32'd1);
        check("async_rst_ce", {31'd0, pix_ce}, 32'd0);
        in_reset = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        repeat (2) tick();
        rst_n = 1'b1; in_reset = 1'b0;
        hs_in = 1'b1; vs_in = 1'b1;
        layer_valid = 4'b0010;
        pixel(); pixel();
        check("rst_cfg_l1", {24'd0, rgb()}, {24'd0, RSTC});

        // Randomised traffic against the model.
        repeat (800) begin
            layer_valid = N'($urandom);
            blank_in    = ($urandom_range(0, 3) == 0);
            hs_in       = ($urandom_range(0, 5) != 0);
            vs_in       = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 15) == 0) vblank_in = ~vblank_in;
            cfg_wr      = ($urandom_range(0, 5) == 0);
            cfg_layer   = 3'($urandom_range(0, 5));
            cfg_en      = ($urandom_range(0, 3) != 0);
            cfg_color   = 8'($urandom);
            tick();
        end
        cfg_wr = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
